// File: rtl/imm_ext_pipe.sv
// Two-stage immediate-extension pipe: rotated DP imm, memory, branch and halfword offsets.
// Latency: 2 cycles input-to-output register; 1 beat/cycle throughput.
// Backpressure: valid/ready chain, 2-entry capacity; flush drops all in-flight entries.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   flush                   cancel both stages at the next edge (blocks input this cycle)
//   in_valid/in_ready       input handshake; immsrc, instr, carry_in, tag_in form the beat
//   out_valid/out_ready     output handshake; extimm, carry_out, tag_out form the beat
module imm_ext_pipe #(
    parameter int DATA_W   = 32,   // even and >= 32
    parameter int TAG_W    = 4,
    parameter int BR_SHIFT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        immsrc,
    input  logic [23:0]       instr,
    input  logic              carry_in,
    input  logic [TAG_W-1:0]  tag_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] extimm,
    output logic              carry_out,
    output logic [TAG_W-1:0]  tag_out
);

    typedef enum logic [1:0] {
        IMM_DP  = 2'b00,
        IMM_MEM = 2'b01,
        IMM_BR  = 2'b10,
        IMM_HW  = 2'b11
    } mode_t;

    // S1 keeps the raw field too: branch needs all 24 bits, the offsets need slices of it.
    typedef struct packed {
        mode_t             mode;
        logic [3:0]        rot;
        logic [7:0]        imm8;
        logic [23:0]       instr;
        logic              carry;
        logic [TAG_W-1:0]  tag;
    } s1_t;

    typedef struct packed {
        logic [DATA_W-1:0] imm;
        logic              carry;
        logic [TAG_W-1:0]  tag;
    } s2_t;

    logic  s1_vld, s2_vld;
    logic  s1_rdy, s2_rdy;
    logic  in_fire;
    s1_t   s1_q, s1_d;
    s2_t   s2_q, s2_d;

    logic [DATA_W-1:0]   zimm8;
    logic [2*DATA_W-1:0] ror_dbl;
    logic [DATA_W-1:0]   br_sext;

    // Ready chain is combinational so a released out_ready frees input the same cycle.
    assign s2_rdy   = !s2_vld || out_ready;
    assign s1_rdy   = !s1_vld || s2_rdy;
    assign in_ready = s1_rdy && !flush;
    assign in_fire  = in_valid && in_ready;

    // Pre-decode into S1
    always_comb begin
        s1_d       = '0;
        s1_d.mode  = mode_t'(immsrc);
        s1_d.rot   = instr[11:8];
        s1_d.imm8  = instr[7:0];
        s1_d.instr = instr;
        s1_d.carry = carry_in;
        s1_d.tag   = tag_in;
    end

    // Extension from S1 payload into S2
    always_comb begin
        zimm8   = {{(DATA_W-8){1'b0}}, s1_q.imm8};
        // Rotate right by shifting a doubled copy; the low half holds the wrapped result.
        ror_dbl = {zimm8, zimm8} >> {s1_q.rot, 1'b0};
        br_sext = {{(DATA_W-24){s1_q.instr[23]}}, s1_q.instr};

        s2_d       = '0;
        s2_d.tag   = s1_q.tag;
        s2_d.carry = s1_q.carry;
        case (s1_q.mode)
            IMM_DP: begin
                s2_d.imm = ror_dbl[DATA_W-1:0];
                // rot = 0 leaves the shifter carry untouched
                if (s1_q.rot != 4'd0) begin
                    s2_d.carry = ror_dbl[DATA_W-1];
                end
            end
            IMM_MEM: s2_d.imm = {{(DATA_W-12){1'b0}}, s1_q.instr[11:0]};
            IMM_BR:  s2_d.imm = br_sext << BR_SHIFT;
            IMM_HW:  s2_d.imm = {{(DATA_W-8){1'b0}}, s1_q.instr[11:8], s1_q.instr[3:0]};
            default: s2_d.imm = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_q   <= '0;
        end else begin
            if (flush) begin
                s1_vld <= 1'b0;
            end else if (s1_rdy) begin
                s1_vld <= in_fire;
            end
            if (in_fire) begin
                s1_q <= s1_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld <= 1'b0;
            s2_q   <= '0;
        end else begin
            if (flush) begin
                s2_vld <= 1'b0;
            end else if (s2_rdy) begin
                s2_vld <= s1_vld;
            end
            if (s2_rdy && s1_vld) begin
                s2_q <= s2_d;
            end
        end
    end

    assign out_valid = s2_vld;
    assign extimm    = s2_q.imm;
    assign carry_out = s2_q.carry;
    assign tag_out   = s2_q.tag;

endmodule

// File: doc/imm_ext_pipe.md
# imm_ext_pipe

Pipelined, parametrised immediate-extension unit for the processor's decode/execute boundary. It accepts an instruction immediate field plus an `immsrc` mode each cycle, and produces the extended operand and shifter carry two cycles later. Four immediate formats are supported:

- rotated data-processing immediate,
- memory offset,
- branch offset,
- split halfword offset.

A valid/ready handshake on both sides allows back-pressure from execute, and `flush` cancels in-flight entries on a branch redirect.

## Interface
- `DATA_W`, 32: width of the extended immediate; must be even and ≥ 32.
- `TAG_W`, 4: width of the sideband tag carried alongside each entry.
- `BR_SHIFT`, 2: left shift applied to the branch offset after sign extension.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  discard all in-flight entries.
- `in_valid`  in  1  the input beat is valid.
- `in_ready`  out  1  the unit can accept the input beat this cycle.
- `immsrc`  in  2  immediate format select.
- `instr`  in  24  instruction bits [23:0].
- `carry_in`  in  1  current C flag, used for the rotate-by-0 case.
- `tag_in`  in  `TAG_W`  sideband tag, passed through unchanged.
- `out_valid`  out  1  the output beat is valid.
- `out_ready`  in  1  downstream accepts the output beat.
- `extimm`  out  `DATA_W`  extended immediate.
- `carry_out`  out  1  shifter carry for the beat.
- `tag_out`  out  `TAG_W`  tag associated with the output beat.

## Operation
- **Format `immsrc` = 00, data-processing immediate:**
  - imm8 = `instr`[7:0]; rot = `instr`[11:8].
  - `extimm` = ROR(zero-extended imm8, 2·rot) within `DATA_W`. No sign extension.
  - `carry_out` = `carry_in` if rot = 0, else `extimm`[DATA_W-1].
- **Format 01, memory offset:** `extimm` = zero-extended `instr`[11:0]; `carry_out` = `carry_in`.
- **Format 10, branch:** `extimm` = sign-extended `instr`[23:0], shifted left by `BR_SHIFT`, truncated to `DATA_W`; `carry_out` = `carry_in`.
- **Format 11, halfword offset:** `extimm` = zero-extended {`instr`[11:8], `instr`[3:0]}; `carry_out` = `carry_in`.
- **Pipeline:** two stages, S1 and S2, each holding a valid bit and a payload.
  - S1 latches `immsrc`, `instr`, `carry_in` and `tag_in`, and pre-decodes imm8, rot and the mode.
  - S2 latches the computed `extimm`, `carry_out` and `tag`, and drives the outputs directly from its registers.
- **Advance rules:**
  - s2_ready = !s2_valid | `out_ready`.
  - s1_ready = !s1_valid | s2_ready.
  - `in_ready` = s1_ready & !`flush`.
- **Transfers:**
  - Input transfer happens when `in_valid` & `in_ready`.
  - Output transfer happens when `out_valid` & `out_ready`.
  - A payload register loads only when its stage advances; a stalled stage holds its payload unchanged.
- **Ordering:** strict FIFO order; no entry is lost or duplicated under any `out_ready` pattern.
- **Flush:**
  - `flush` forces `in_ready` low.
  - An output transfer in the flush cycle still completes.
  - At the next edge both valids clear. Payloads need not clear.

## Timing
- **Latency:** an input accepted at edge N appears on `out_valid`/`extimm` after edge N+1, i.e. two cycles input-to-output register.
- **Throughput:** one beat per cycle when `out_ready` is held high.
- **Capacity:** 2 entries. With `out_ready` = 0, `in_ready` falls after two accepted beats. Raising `out_ready` lets `in_ready` rise in the same cycle (combinational ready chain).
- **Reset values:**
  - On `rst_n` low, asynchronously: `out_valid` = 0, s1_valid = 0, `extimm` = 0, `carry_out` = 0, `tag_out` = 0.
  - `in_ready` = 1 once `rst_n` is high.
  - Reset mid-operation discards all entries.
- **Boundaries:**
  - rot = 0 gives identity with carry pass-through.
  - rot = 15 gives ROR 30.
  - `instr`[23] = 1 in branch mode fills the upper bits with 1.
  - `flush` together with `in_valid` accepts nothing.
  - `flush` while stalled clears both entries.

## Test plan
- **Data-processing immediate:** `immsrc` = 00, `instr` = 0x0004FF, `carry_in` = 0 → `extimm` = 0xFF000000, `carry_out` = 1. `instr` = 0x0000FF, `carry_in` = 1 → 0x000000FF, `carry_out` = 1. `instr` = 0x000F01 → 0x00000004, `carry_out` = 0.
- **Memory and halfword offsets:** `immsrc` = 01, `instr` = 0xABCFFF → 0x00000FFF (no sign extension). `immsrc` = 11, `instr` = 0x000A05 → 0x000000A5.
- **Branch:** `immsrc` = 10, `instr` = 0xFFFFFE → 0xFFFFFFF8. `instr` = 0x000010 → 0x00000040. `instr` = 0x7FFFFF → 0x01FFFFFC.
- **Back-pressure:** `out_ready` = 0; push tags 1, 2, 3 → `in_ready` low after tags 1 and 2. Release `out_ready` → outputs tags 1, 2, 3 in order, each with the correct `extimm`, no gaps beyond one cycle.
- **Streaming:** 16 back-to-back beats with `out_ready` = 1 → first output two cycles after the first input, then one per cycle.
- **Flush and reset:** two entries in flight, pulse `flush` for one cycle → `out_valid` = 0 next cycle and `in_ready` = 1. Assert `rst_n` = 0 mid-stream → outputs go to zero immediately, with no output after release until new input arrives.
